// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM frame arbiter: FSM states,
// owner codes, request-vector bit positions and the full byte-enable mask.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    localparam int unsigned REQ_DISP = 0;
    localparam int unsigned REQ_VID  = 1;
    localparam int unsigned REQ_CPU  = 2;
    localparam int unsigned N_REQ    = 3;

    localparam logic [1:0] BE_ALL = 2'b11;

endpackage

// File: rtl/sram_arb_select.sv
// Grant selection for the SRAM arbiter: display always wins; video/CPU are
// fixed-priority by default, or round-robin when SRAM_ARB_RR_EN is defined.
module sram_arb_select
    import sram_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic             rr_ptr_nxt
);

    always_comb begin
        grant      = '0;
        rr_ptr_nxt = rr_ptr;
`ifdef SRAM_ARB_RR_EN
        // rr_ptr = 0 favours video, 1 favours CPU; it flips to the other port after each grant
        if (req[REQ_DISP]) begin
            grant[REQ_DISP] = 1'b1;
        end else if (req[REQ_VID] && (!req[REQ_CPU] || !rr_ptr)) begin
            grant[REQ_VID] = 1'b1;
            rr_ptr_nxt     = 1'b1;
        end else if (req[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
            rr_ptr_nxt     = 1'b0;
        end
`else
        if (req[REQ_DISP]) begin
            grant[REQ_DISP] = 1'b1;
        end else if (req[REQ_VID]) begin
            grant[REQ_VID] = 1'b1;
        end else if (req[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/sram_frame_arbiter.sv
// Three-port async SRAM arbiter (display read, video write, CPU read/write) with
// registered strobes and DQ enable. Define SRAM_ARB_RR_EN for video/CPU round-robin.
module sram_frame_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [DATA_W-1:0] vid_wdata,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_be,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        owner,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    arb_state_t        state, state_nxt;
    logic [1:0]        cur_own, nxt_own;
    logic              cur_we, nxt_we;
    logic [BE_W-1:0]   cur_be, nxt_be;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;
    logic              rr_ptr, rr_ptr_nxt;
    logic [N_REQ-1:0]  req_vec, req_masked, grant;
    logic              take;

    logic ce_n_nxt, oe_n_nxt, we_n_nxt, lb_n_nxt, ub_n_nxt, dq_oe_nxt;
    logic disp_ack_nxt, vid_ack_nxt, cpu_ack_nxt;
    logic [1:0] owner_nxt;

    assign req_vec = {cpu_req, vid_req, disp_req};
    assign take    = |grant;

    // Arbitration only happens in IDLE and DONE; in DONE the finishing owner is
    // masked because its request is still held during its ack cycle.
    always_comb begin
        req_masked = '0;
        if (state == IDLE) begin
            req_masked = req_vec;
        end else if (state == DONE) begin
            req_masked = req_vec;
            case (cur_own)
                OWN_DISP: req_masked[REQ_DISP] = 1'b0;
                OWN_VID:  req_masked[REQ_VID]  = 1'b0;
                OWN_CPU:  req_masked[REQ_CPU]  = 1'b0;
                default:  ;
            endcase
        end
    end

    sram_arb_select u_select (
        .req        (req_masked),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .rr_ptr_nxt (rr_ptr_nxt)
    );

    always_comb begin
        state_nxt = state;
        nxt_own   = cur_own;
        nxt_we    = cur_we;
        nxt_be    = cur_be;
        nxt_addr  = sram_addr;
        nxt_wdata = sram_dq_out;
        case (state)
            IDLE:    if (take) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = take ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (take) begin
            if (grant[REQ_DISP]) begin
                nxt_own   = OWN_DISP;
                nxt_we    = 1'b0;
                nxt_be    = BE_ALL;
                nxt_addr  = disp_addr;
                nxt_wdata = '0;
            end else if (grant[REQ_VID]) begin
                nxt_own   = OWN_VID;
                nxt_we    = 1'b1;
                nxt_be    = BE_ALL;
                nxt_addr  = vid_addr;
                nxt_wdata = vid_wdata;
            end else begin
                nxt_own   = OWN_CPU;
                nxt_we    = cpu_we;
                nxt_be    = cpu_be;
                nxt_addr  = cpu_addr;
                nxt_wdata = cpu_wdata;
            end
        end
    end

    // Output values are decoded from the next state so every pin is a flop output.
    always_comb begin
        ce_n_nxt     = 1'b1;
        oe_n_nxt     = 1'b1;
        we_n_nxt     = 1'b1;
        lb_n_nxt     = 1'b1;
        ub_n_nxt     = 1'b1;
        dq_oe_nxt    = 1'b0;
        disp_ack_nxt = 1'b0;
        vid_ack_nxt  = 1'b0;
        cpu_ack_nxt  = 1'b0;
        owner_nxt    = OWN_NONE;
        case (state_nxt)
            SETUP, ACCESS: begin
                ce_n_nxt  = 1'b0;
                lb_n_nxt  = ~nxt_be[0];
                ub_n_nxt  = ~nxt_be[1];
                oe_n_nxt  = nxt_we;
                dq_oe_nxt = nxt_we;
                we_n_nxt  = (state_nxt == ACCESS) ? ~nxt_we : 1'b1;
                owner_nxt = nxt_own;
            end
            DONE: begin
                owner_nxt    = nxt_own;
                disp_ack_nxt = (nxt_own == OWN_DISP);
                vid_ack_nxt  = (nxt_own == OWN_VID);
                cpu_ack_nxt  = (nxt_own == OWN_CPU);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_own     <= OWN_NONE;
            cur_we      <= 1'b0;
            cur_be      <= '0;
            rr_ptr      <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            disp_ack    <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            owner       <= OWN_NONE;
            rd_data     <= '0;
        end else begin
            state       <= state_nxt;
            cur_own     <= nxt_own;
            cur_we      <= nxt_we;
            cur_be      <= nxt_be;
            rr_ptr      <= rr_ptr_nxt;
            sram_addr   <= nxt_addr;
            sram_dq_out <= nxt_wdata;
            sram_dq_oe  <= dq_oe_nxt;
            sram_ce_n   <= ce_n_nxt;
            sram_oe_n   <= oe_n_nxt;
            sram_we_n   <= we_n_nxt;
            sram_lb_n   <= lb_n_nxt;
            sram_ub_n   <= ub_n_nxt;
            disp_ack    <= disp_ack_nxt;
            vid_ack     <= vid_ack_nxt;
            cpu_ack     <= cpu_ack_nxt;
            owner       <= owner_nxt;
            if (state == ACCESS && !cur_we) begin
                rd_data <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed self-checking bench for sram_frame_arbiter with a small SRAM model.
module tb_sram_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [19:0] disp_addr = '0;
    logic        disp_ack;
    logic        vid_req = 1'b0;
    logic [19:0] vid_addr = '0;
    logic [15:0] vid_wdata = '0;
    logic        vid_ack;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [1:0]  cpu_be = 2'b11;
    logic        cpu_ack;
    logic [15:0] rd_data;
    logic [1:0]  owner;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_frame_arbiter #(.ADDR_W(20), .DATA_W(16), .BE_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_wdata(vid_wdata), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack),
        .rd_data(rd_data), .owner(owner),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    // Async SRAM model: byte-lane write while CE/WE low, full word read while CE/OE low
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
        end
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hFFFF;

    function automatic logic [5:0] strobes();
        return {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic saw_ack;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        n_total++;
        if (strobes() !== 6'b111110) $display("FAIL reset_strobes: got %b expected %b", strobes(), 6'b111110);
        else n_pass++;
        n_total++;
        if ({owner, disp_ack, vid_ack, cpu_ack} !== 5'b0) $display("FAIL reset_owner_acks: got %b expected %b", {owner, disp_ack, vid_ack, cpu_ack}, 5'b0);
        else n_pass++;
        n_total++;
        if ({rd_data, sram_addr, sram_dq_out} !== 52'h0) $display("FAIL reset_data: got %h expected %h", {rd_data, sram_addr, sram_dq_out}, 52'h0);
        else n_pass++;
        // cpu write aborted by reset in ACCESS
        cpu_we = 1'b1; cpu_addr = 20'h77; cpu_wdata = 16'hABCD; cpu_be = 2'b11; cpu_req = 1'b1;
        tick();
        tick();
        n_total++;
        if (sram_we_n !== 1'b0) $display("FAIL reset_pre_access_we_n: got %b expected %b", sram_we_n, 1'b0);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (strobes() !== 6'b111110) $display("FAIL reset_mid_access_strobes: got %b expected %b", strobes(), 6'b111110);
        else n_pass++;
        n_total++;
        if (owner !== 2'd0) $display("FAIL reset_mid_access_owner: got %0d expected %0d", owner, 0);
        else n_pass++;
        cpu_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        saw_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ack) saw_ack = 1'b1;
        end
        n_total++;
        if (saw_ack !== 1'b0) $display("FAIL reset_no_ack: got %b expected %b", saw_ack, 1'b0);
        else n_pass++;
    endtask

    task automatic test_cpu_write();
        cpu_we = 1'b1; cpu_addr = 20'h00010; cpu_wdata = 16'h1234; cpu_be = 2'b11; cpu_req = 1'b1;
        tick();
        n_total++;
        if (strobes() !== 6'b011001) $display("FAIL wr_setup_strobes: got %b expected %b", strobes(), 6'b011001);
        else n_pass++;
        n_total++;
        if ({owner, sram_addr, sram_dq_out} !== {2'd3, 20'h00010, 16'h1234}) $display("FAIL wr_setup_bus: got %h expected %h", {owner, sram_addr, sram_dq_out}, {2'd3, 20'h00010, 16'h1234});
        else n_pass++;
        tick();
        n_total++;
        if (strobes() !== 6'b010001) $display("FAIL wr_access_strobes: got %b expected %b", strobes(), 6'b010001);
        else n_pass++;
        tick();
        n_total++;
        if ({cpu_ack, strobes()} !== 7'b1111110) $display("FAIL wr_done_ack: got %b expected %b", {cpu_ack, strobes()}, 7'b1111110);
        else n_pass++;
        cpu_req = 1'b0;
        tick();
        n_total++;
        if ({cpu_ack, owner} !== 3'b000) $display("FAIL wr_idle_after: got %b expected %b", {cpu_ack, owner}, 3'b000);
        else n_pass++;
        n_total++;
        if (mem[8'h10] !== 16'h1234) $display("FAIL wr_mem: got %h expected %h", mem[8'h10], 16'h1234);
        else n_pass++;
    endtask

    task automatic test_cpu_read();
        cpu_we = 1'b0; cpu_addr = 20'h00010; cpu_be = 2'b11; cpu_req = 1'b1;
        tick();
        n_total++;
        if (strobes() !== 6'b001000) $display("FAIL rd_setup_strobes: got %b expected %b", strobes(), 6'b001000);
        else n_pass++;
        tick();
        n_total++;
        if (strobes() !== 6'b001000) $display("FAIL rd_access_strobes: got %b expected %b", strobes(), 6'b001000);
        else n_pass++;
        tick();
        n_total++;
        if ({cpu_ack, rd_data} !== {1'b1, 16'h1234}) $display("FAIL rd_done_data: got %h expected %h", {cpu_ack, rd_data}, {1'b1, 16'h1234});
        else n_pass++;
        cpu_req = 1'b0;
        tick();
        cpu_be = 2'b01; cpu_req = 1'b1;
        tick();
        n_total++;
        if ({sram_lb_n, sram_ub_n} !== 2'b01) $display("FAIL rd_be01_lanes: got %b expected %b", {sram_lb_n, sram_ub_n}, 2'b01);
        else n_pass++;
        tick();
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_we = 1'b1; cpu_addr = 20'h00011; cpu_be = 2'b00; cpu_req = 1'b1;
        tick();
        n_total++;
        if ({sram_ce_n, sram_lb_n, sram_ub_n} !== 3'b011) $display("FAIL be00_lanes: got %b expected %b", {sram_ce_n, sram_lb_n, sram_ub_n}, 3'b011);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (cpu_ack !== 1'b1) $display("FAIL be00_ack: got %b expected %b", cpu_ack, 1'b1);
        else n_pass++;
        cpu_req = 1'b0;
        cpu_be = 2'b11;
        tick();
    endtask

    task automatic test_all_three();
        int disp_at, vid_at, cpu_at;
        logic [15:0] disp_d, cpu_d;
        disp_at = 0; vid_at = 0; cpu_at = 0; disp_d = '0; cpu_d = '0;
        cpu_we = 1'b1; cpu_addr = 20'h20; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
        tick(); tick(); tick();
        cpu_req = 1'b0;
        tick();
        disp_addr = 20'h20; disp_req = 1'b1;
        vid_addr = 20'h30; vid_wdata = 16'h5A5A; vid_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 20'h10; cpu_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1 || c == 4 || c == 7) begin
                n_total++;
                if (owner !== 2'((c - 1) / 3 + 1)) $display("FAIL all3_owner_c%0d: got %0d expected %0d", c, owner, (c - 1) / 3 + 1);
                else n_pass++;
            end
            if (disp_ack) begin disp_at = c; disp_d = rd_data; disp_req = 1'b0; end
            if (vid_ack)  begin vid_at = c;  vid_req = 1'b0; end
            if (cpu_ack)  begin cpu_at = c;  cpu_d = rd_data; cpu_req = 1'b0; end
        end
        n_total++;
        if ({disp_at, vid_at, cpu_at} !== {32'd3, 32'd6, 32'd9}) $display("FAIL all3_ack_cycles: got %0d,%0d,%0d expected 3,6,9", disp_at, vid_at, cpu_at);
        else n_pass++;
        n_total++;
        if ({disp_d, cpu_d} !== {16'hBEEF, 16'h1234}) $display("FAIL all3_rd_data: got %h expected %h", {disp_d, cpu_d}, {16'hBEEF, 16'h1234});
        else n_pass++;
        n_total++;
        if (mem[8'h30] !== 16'h5A5A) $display("FAIL all3_vid_mem: got %h expected %h", mem[8'h30], 16'h5A5A);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic clash;
        clash = 1'b0;
        disp_addr = 20'h30; disp_req = 1'b1;
        vid_addr = 20'h40; vid_wdata = 16'h0F0F; vid_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (sram_dq_oe && !sram_oe_n) clash = 1'b1;
            if (c == 3) begin
                n_total++;
                if ({disp_ack, sram_oe_n, sram_dq_oe, rd_data} !== {3'b110, 16'h5A5A}) $display("FAIL b2b_done_turnaround: got %h expected %h", {disp_ack, sram_oe_n, sram_dq_oe, rd_data}, {3'b110, 16'h5A5A});
                else n_pass++;
                disp_req = 1'b0;
            end
            if (c == 4) begin
                n_total++;
                if ({owner, sram_oe_n, sram_dq_oe} !== 4'b1011) $display("FAIL b2b_wr_setup: got %b expected %b", {owner, sram_oe_n, sram_dq_oe}, 4'b1011);
                else n_pass++;
            end
            if (vid_ack) vid_req = 1'b0;
        end
        n_total++;
        if (clash !== 1'b0) $display("FAIL b2b_contention: got %b expected %b", clash, 1'b0);
        else n_pass++;
        n_total++;
        if (mem[8'h40] !== 16'h0F0F) $display("FAIL b2b_vid_mem: got %h expected %h", mem[8'h40], 16'h0F0F);
        else n_pass++;
    endtask

    task automatic test_vid_cpu();
        int vid_n, cpu_n;
        logic [1:0] exp_first;
        vid_n = 0; cpu_n = 0;
        vid_addr = 20'h50; vid_wdata = 16'h1111; vid_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 20'h10; cpu_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c % 3 == 1) begin
                n_total++;
                if (owner !== ((c == 1 || c == 7) ? 2'd2 : 2'd3)) $display("FAIL vidcpu_owner_c%0d: got %0d expected %0d", c, owner, (c == 1 || c == 7) ? 2 : 3);
                else n_pass++;
            end
            if (vid_ack) vid_n++;
            if (cpu_ack) cpu_n++;
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        n_total++;
        if ({vid_n, cpu_n} !== {32'd2, 32'd2}) $display("FAIL vidcpu_ack_counts: got %0d,%0d expected 2,2", vid_n, cpu_n);
        else n_pass++;
        tick();
        vid_req = 1'b1;
        tick(); tick(); tick();
        vid_req = 1'b0;
        tick();
`ifdef SRAM_ARB_RR_EN
        exp_first = 2'd3;
`else
        exp_first = 2'd2;
`endif
        vid_req = 1'b1; cpu_req = 1'b1;
        tick();
        n_total++;
        if (owner !== exp_first) $display("FAIL vidcpu_simul_winner: got %0d expected %0d", owner, exp_first);
        else n_pass++;
        for (int c = 2; c <= 7; c++) begin
            tick();
            if (vid_ack) vid_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
        end
        n_total++;
        if ({vid_req, cpu_req, owner} !== 4'b0) $display("FAIL vidcpu_drain: got %b expected %b", {vid_req, cpu_req, owner}, 4'b0);
        else n_pass++;
    endtask

    task automatic test_disp_hold();
        int vid_at, disp_n;
        vid_at = 0; disp_n = 0;
        disp_addr = 20'h20; disp_req = 1'b1;
        vid_addr = 20'h60; vid_wdata = 16'h2222; vid_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1 || c == 4 || c == 7) begin
                n_total++;
                if (owner !== ((c == 4) ? 2'd2 : 2'd1)) $display("FAIL disphold_owner_c%0d: got %0d expected %0d", c, owner, (c == 4) ? 2 : 1);
                else n_pass++;
            end
            if (vid_ack) begin vid_at = c; vid_req = 1'b0; end
            if (disp_ack) disp_n++;
        end
        disp_req = 1'b0;
        n_total++;
        if (vid_at !== 6) $display("FAIL disphold_vid_ack_cycle: got %0d expected %0d", vid_at, 6);
        else n_pass++;
        n_total++;
        if (disp_n !== 2) $display("FAIL disphold_disp_acks: got %0d expected %0d", disp_n, 2);
        else n_pass++;
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_all_three();
        test_back_to_back();
        test_vid_cpu();
        test_disp_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
